fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_stage.sv | 50 +++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, increment, NOP encoding and FSM states for the fetch stage
package fetch_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 32;
  localparam int PC_INCR = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner feeding 1-cycle IMEM (CLK, RST, STALL, REDIRECT_EN/PC, IMEM_instruction in; MEM_PC, IF_instruction, IF_PC, IF_PC4, IF_valid out)
module fetch_stage #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALL,
  input  logic               REDIRECT_EN,
  input  logic [PC_W-1:0]    REDIRECT_PC,
  input  logic [INSTR_W-1:0] IMEM_instruction,
  output logic [PC_W-1:0]    MEM_PC,
  output logic [INSTR_W-1:0] IF_instruction,
  output logic [PC_W-1:0]    IF_PC,
  output logic [PC_W-1:0]    IF_PC4,
  output logic               IF_valid
);
  import fetch_pkg::*;
  localparam logic [PC_W-1:0] INCR = PC_W'(PC_INCR);
  state_t state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_nxt, rsp_pc, rsp_nxt;
  logic [INSTR_W-1:0] hold_reg, hold_nxt;
  logic advance;
  always_comb begin
    advance = !REDIRECT_EN && (state == FILL || !STALL);
    state_nxt = REDIRECT_EN ? FILL : advance ? RUN : HOLD;
    fetch_nxt = REDIRECT_EN ? (REDIRECT_PC & ~PC_W'(3)) : advance ? fetch_pc + INCR : fetch_pc;
    rsp_nxt = advance ? fetch_pc : rsp_pc;
    hold_nxt = (!REDIRECT_EN && state == RUN && STALL) ? IMEM_instruction : hold_reg;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FILL;
      fetch_pc <= RESET_PC;
      rsp_pc <= '0;
      hold_reg <= '0;
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_nxt;
      rsp_pc <= rsp_nxt;
      hold_reg <= hold_nxt;
    end
  end
  assign MEM_PC = fetch_pc;
  assign IF_valid = state != FILL;
  assign IF_PC = rsp_pc;
  assign IF_PC4 = rsp_pc + INCR;
  assign IF_instruction = state == RUN ? IMEM_instruction : state == HOLD ? hold_reg : INSTR_W'(NOP_INSTR);
endmodule
